// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: one read/write at a time, fixed latency, Done pulse.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses end with Error).
module mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ReqRead,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] MemRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWr,
  output logic [DATA_W-1:0] RdData,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic              req;

  assign req = ReqRead | ReqWrite;

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic misal;

  assign misal = (Addr[1:0] != 2'b00);

  // Error flag: set on a misaligned accept, only meaningful in DONE
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  always_comb begin
    err_d = 1'b0;
    if (state_q == IDLE && req && misal) err_d = 1'b1;
  end

  assign Error = (state_q == DONE) && err_q;
`else
  assign Error = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state, latency counting and read-data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          wr_d = ReqWrite;
`ifdef MEM_ALIGN_CHECK_EN
          if (misal) begin
            state_d = DONE;
          end else begin
            state_d = ACCESS;
            addr_d  = Addr;
            wdata_d = WrData;
          end
`else
          state_d = ACCESS;
          addr_d  = Addr & {{(ADDR_W-2){1'b1}}, 2'b00};
          wdata_d = WrData;
`endif
        end
      end
      ACCESS: begin
        if (WAIT_CYCLES == 0) begin
          state_d = DONE;
          if (!wr_q) rdata_d = MemRData;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!wr_q) rdata_d = MemRData;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign RdData   = rdata_q;
  assign MemWr    = (state_q == ACCESS) && wr_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);

endmodule
